// File: rtl/fixed3_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fixed3_norm_arbiter
//  Purpose  : Round-robin front end that shares one non-pipelined Fixed3
//             normalize unit (sqrt + three iterative dividers) between
//             NUM_REQ requesters. Holds the operand for the whole operation,
//             waits for the normalizer, returns the result to the granted
//             requester and times out a hung operation.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             req, req_v       - per-requester request level and operand
//             done, done_err   - one-cycle completion pulse, timeout flag
//             res_v, res_vn    - Fixed3 / FixedNorm3 result, valid with done
//             busy, grant_id   - activity flag, current/last grant index
//             norm_strobe/_v   - start pulse and operand to the normalizer
//             norm_valid/_ov/_ovn - normalizer completion and results
//  Revision : 1.0 - initial release
// ============================================================================
module fixed3_norm_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int FW      = 32,
    parameter int NW      = 16,
    parameter int TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*3*FW-1:0]    req_v,
    output logic [NUM_REQ-1:0]         done,
    output logic                       done_err,
    output logic [3*FW-1:0]            res_v,
    output logic [3*NW-1:0]            res_vn,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       norm_strobe,
    output logic [3*FW-1:0]            norm_v,
    input  logic                       norm_valid,
    input  logic [3*FW-1:0]            norm_ov,
    input  logic [3*NW-1:0]            norm_ovn
);

    localparam int c_gw  = $clog2(NUM_REQ);
    localparam int c_vw  = 3 * FW;
    localparam int c_nvw = 3 * NW;
    // A disabled timeout still gets a 1-bit counter so no zero-width vector exists.
    localparam int c_cw  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cw-1:0] c_to_last = c_cw'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_gw-1:0]   r_grant;
    logic [c_gw-1:0]   r_last;
    logic [c_vw-1:0]   r_norm_v;
    logic [c_vw-1:0]   r_res_v;
    logic [c_nvw-1:0]  r_res_vn;
    logic              r_done_err;
    logic [c_cw-1:0]   r_cnt;

    logic              w_found;
    logic [c_gw-1:0]   w_winner;
    int                w_idx;
    logic              w_timeout;

    // Round-robin pick: first set request scanning upward from last+1 with
    // wrap-around, so the most recently served requester has lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = c_gw'(w_idx);
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_to_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a normalizer completion outside WAIT is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_found) w_state_nxt = c_st_issue;
            c_st_issue: w_state_nxt = c_st_wait;
            c_st_wait:  if (norm_valid || w_timeout) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Datapath registers. The operand latch only loads at a new grant, which
    // keeps norm_v stable from ISSUE through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_last     <= c_gw'(NUM_REQ - 1);
            r_norm_v   <= '0;
            r_res_v    <= '0;
            r_res_vn   <= '0;
            r_done_err <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_grant  <= w_winner;
                        r_last   <= w_winner;
                        r_norm_v <= req_v[int'(w_winner)*c_vw +: c_vw];
                    end
                end
                c_st_issue: begin
                    r_cnt <= '0;
                end
                c_st_wait: begin
                    // A completion on the timeout cycle takes precedence.
                    if (norm_valid) begin
                        r_res_v    <= norm_ov;
                        r_res_vn   <= norm_ovn;
                        r_done_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_res_v    <= '0;
                        r_res_vn   <= '0;
                        r_done_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        norm_strobe = (r_state == c_st_issue);
        busy        = (r_state != c_st_idle);
        done        = '0;
        if (r_state == c_st_done) begin
            done = NUM_REQ'(1) << r_grant;
        end
    end

    assign done_err = r_done_err;
    assign res_v    = r_res_v;
    assign res_vn   = r_res_vn;
    assign grant_id = r_grant;
    assign norm_v   = r_norm_v;

endmodule
`default_nettype wire

// File: tb/tb_fixed3_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fixed3_norm_arbiter
//  Purpose  : Directed self-checking bench for fixed3_norm_arbiter. Instance
//             A (TIMEOUT=256) is served by a fixed-latency normalizer stub;
//             instance B (TIMEOUT=16) has its normalizer driven by hand for
//             the timeout and same-cycle race cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fixed3_norm_arbiter;

    localparam logic [95:0] C_V345  = {32'h0004_0000, 32'h0000_0000, 32'h0003_0000};
    localparam logic [95:0] C_GARB  = {3{32'hBAD0_BAD0}};
    localparam logic [47:0] C_GARBN = {3{16'hDEAD}};

    logic clk;
    logic rst;

    logic [2:0]  req_a,  req_b;
    logic [287:0] req_v;
    logic [2:0]  done_a, done_b;
    logic        done_err_a, done_err_b;
    logic [95:0] res_v_a, res_v_b;
    logic [47:0] res_vn_a, res_vn_b;
    logic        busy_a, busy_b;
    logic [1:0]  grant_id_a, grant_id_b;
    logic        norm_strobe_a, norm_strobe_b;
    logic [95:0] norm_v_a, norm_v_b;
    logic        norm_valid_a, norm_valid_b;
    logic [95:0] norm_ov_a, norm_ov_b;
    logic [47:0] norm_ovn_a, norm_ovn_b;

    logic [95:0] vecs [3];
    int          lat_a;
    int          n_checks;
    int          n_errors;

    fixed3_norm_arbiter #(.NUM_REQ(3), .FW(32), .NW(16), .TIMEOUT(256)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_v(req_v),
        .done(done_a), .done_err(done_err_a), .res_v(res_v_a), .res_vn(res_vn_a),
        .busy(busy_a), .grant_id(grant_id_a), .norm_strobe(norm_strobe_a),
        .norm_v(norm_v_a), .norm_valid(norm_valid_a), .norm_ov(norm_ov_a),
        .norm_ovn(norm_ovn_a)
    );

    fixed3_norm_arbiter #(.NUM_REQ(3), .FW(32), .NW(16), .TIMEOUT(16)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_v(req_v),
        .done(done_b), .done_err(done_err_b), .res_v(res_v_b), .res_vn(res_vn_b),
        .busy(busy_b), .grant_id(grant_id_b), .norm_strobe(norm_strobe_b),
        .norm_v(norm_v_b), .norm_valid(norm_valid_b), .norm_ov(norm_ov_b),
        .norm_ovn(norm_ovn_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Normalizer stand-in: (3,0,4) maps to the true unit vector (0.6,0,0.8);
    // any other operand maps to a fixed scramble so results stay traceable.
    function automatic logic [95:0] fn(input logic [95:0] v);
        if (v == C_V345) return {32'h0000_CCCC, 32'h0000_0000, 32'h0000_9999};
        return v ^ {3{32'h5A5A_0F0F}};
    endfunction

    function automatic logic [47:0] fnn(input logic [47:0] v_lo);
        if (v_lo == C_V345[47:0]) return {16'h6666, 16'h0000, 16'h4CCC};
        return v_lo ^ 48'h1234_5678_9ABC;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Fixed-latency responder for instance A; not affected by rst, so a
    // completion for an aborted operation still arrives (stale).
    initial begin
        logic [95:0] cap;
        norm_valid_a = 1'b0;
        norm_ov_a    = C_GARB;
        norm_ovn_a   = C_GARBN;
        forever begin
            @(negedge clk);
            if (norm_strobe_a === 1'b1) begin
                cap = norm_v_a;
                repeat (lat_a) @(negedge clk);
                norm_valid_a = 1'b1;
                norm_ov_a    = fn(cap);
                norm_ovn_a   = fnn(cap[47:0]);
                @(negedge clk);
                norm_valid_a = 1'b0;
                norm_ov_a    = C_GARB;
                norm_ovn_a   = C_GARBN;
            end
        end
    end

    // Called on the strobe cycle of an expected grant to requester k on A.
    task automatic op_a(input int k, input logic [2:0] next_req);
        logic [95:0] v;
        logic [2:0]  m;
        v = vecs[k];
        m = 3'(1 << k);
        check("a_strobe", norm_strobe_a, 1);
        check("a_grant", grant_id_a, k);
        check("a_norm_v", norm_v_a, v);
        tick(lat_a);
        check("a_done_early", done_a, 0);
        tick(1);
        check("a_done", done_a, m);
        check("a_done_err", done_err_a, 0);
        check("a_res_v", res_v_a, fn(v));
        check("a_res_vn", res_vn_a, fnn(v[47:0]));
        check("a_norm_v_hold", norm_v_a, v);
        req_a = next_req;
        tick(2);
    endtask

    // Called on the strobe cycle of an expected grant to requester k on B.
    // vcyc = cycles after strobe at which norm_valid is driven; 0 = never.
    task automatic op_b(input int k, input int vcyc, input logic [2:0] next_req);
        logic [95:0] v;
        logic [2:0]  m;
        v = vecs[k];
        m = 3'(1 << k);
        check("b_strobe", norm_strobe_b, 1);
        check("b_grant", grant_id_b, k);
        check("b_norm_v", norm_v_b, v);
        if (vcyc > 0) begin
            tick(vcyc);
            norm_valid_b = 1'b1;
            norm_ov_b    = fn(v);
            norm_ovn_b   = fnn(v[47:0]);
            check("b_done_early", done_b, 0);
            tick(1);
            norm_valid_b = 1'b0;
            norm_ov_b    = C_GARB;
            norm_ovn_b   = C_GARBN;
            check("b_done", done_b, m);
            check("b_done_err", done_err_b, 0);
            check("b_res_v", res_v_b, fn(v));
            check("b_res_vn", res_vn_b, fnn(v[47:0]));
        end else begin
            tick(16);
            check("b_to_early", done_b, 0);
            check("b_to_busy", busy_b, 1);
            tick(1);
            check("b_to_done", done_b, m);
            check("b_to_err", done_err_b, 1);
            check("b_to_res_v", res_v_b, 0);
            check("b_to_res_vn", res_vn_b, 0);
        end
        req_b = next_req;
        tick(2);
    endtask

    initial begin
        int seen;
        n_checks     = 0;
        n_errors     = 0;
        lat_a        = 40;
        rst          = 1'b1;
        req_a        = '0;
        req_b        = '0;
        norm_valid_b = 1'b0;
        norm_ov_b    = C_GARB;
        norm_ovn_b   = C_GARBN;
        vecs[0] = C_V345;
        vecs[1] = {32'h0001_2345, 32'hFFFE_8000, 32'h0000_7777};
        vecs[2] = {32'h8000_0001, 32'h0010_0000, 32'hFFFF_FFFF};
        req_v   = {vecs[2], vecs[1], vecs[0]};

        // Reset state
        tick(3);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_done_err", done_err_a, 0);
        check("rst_strobe", norm_strobe_a, 0);
        check("rst_norm_v", norm_v_a, 0);
        check("rst_res_v", res_v_a, 0);
        check("rst_res_vn", res_vn_a, 0);
        check("rst_grant", grant_id_a, 0);
        rst = 1'b0;
        tick(1);

        // Single request, latency 40: strobe next cycle, done 41 after strobe
        req_a = 3'b001;
        tick(1);
        op_a(0, 3'b000);

        // Simultaneous requests from reset: order 0,1,2
        lat_a = 5;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req_a = 3'b111;
        tick(1);
        op_a(0, 3'b110);
        op_a(1, 3'b100);
        op_a(2, 3'b000);
        check("a_idle_strobe", norm_strobe_a, 0);
        check("a_idle_busy", busy_a, 0);

        // Fairness: serve 1, then hold 011 -> 0,1,0,1...
        req_a = 3'b010;
        tick(1);
        op_a(1, 3'b011);
        for (int i = 0; i < 20; i++) begin
            op_a(i % 2, (i == 19) ? 3'b000 : 3'b011);
        end

        // Reset mid-WAIT, stale completion afterwards
        lat_a = 20;
        req_a = 3'b100;
        tick(1);
        check("rw_strobe", norm_strobe_a, 1);
        check("rw_grant", grant_id_a, 2);
        tick(14);
        check("rw_busy_wait", busy_a, 1);
        rst   = 1'b1;
        req_a = 3'b000;
        tick(1);
        rst = 1'b0;
        check("rw_busy", busy_a, 0);
        check("rw_grant_rst", grant_id_a, 0);
        check("rw_norm_v", norm_v_a, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (done_a != 3'b000 || busy_a != 1'b0) seen++;
        end
        check("rw_no_done", seen, 0);
        check("rw_res_v", res_v_a, 0);
        check("rw_res_vn", res_vn_a, 0);
        lat_a = 5;
        req_a = 3'b111;
        tick(1);
        op_a(0, 3'b000);

        // Instance B: normal, timeout, normal again, same-cycle race
        req_b = 3'b001;
        tick(1);
        op_b(0, 3, 3'b010);
        op_b(1, 0, 3'b100);
        check("b_err_hold", done_err_b, 1);
        check("b_res_hold", res_v_b, 0);
        op_b(2, 7, 3'b001);
        op_b(0, 16, 3'b000);
        check("b_idle_busy", busy_b, 0);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
